// File: rtl/branch_stack.sv
// Branch checkpoint stack: one-hot tags per in-flight branch, snapshotting free list,
// map table and ROB tail, with same-cycle restore and younger-tag squash on mispredict.
module branch_stack #(
  parameter int DEPTH        = 4,
  parameter int ROB_IDX_BITS = 5,
  parameter int PHYS_REG_SZ  = 64,
  parameter int ARCH_REG_SZ  = 32,
  parameter int PHYS_REG_IDX = 6
) (
  input  logic                                 clock,
  input  logic                                 reset,
  input  logic                                 branch_dispatch_valid,
  input  logic [PHYS_REG_SZ-1:0]               free_list_snapshot,
  input  logic [ARCH_REG_SZ*PHYS_REG_IDX-1:0]  map_table_snapshot,
  input  logic [ROB_IDX_BITS-1:0]              rob_tail_snapshot,
  input  logic                                 resolve_valid,
  input  logic [DEPTH-1:0]                     resolve_mask,
  input  logic                                 resolve_mispredict,
  output logic                                 branch_stack_full,
  output logic [DEPTH-1:0]                     assigned_branch_mask,
  output logic [DEPTH-1:0]                     current_branch_mask,
  output logic [DEPTH-1:0]                     resolved_mask,
  output logic [DEPTH-1:0]                     squash_mask,
  output logic                                 restore_flag,
  output logic [PHYS_REG_SZ-1:0]               free_list_restore,
  output logic [ARCH_REG_SZ*PHYS_REG_IDX-1:0]  map_table_restore,
  output logic [ROB_IDX_BITS-1:0]              rob_tail_restore
);

  localparam int MT_W  = ARCH_REG_SZ * PHYS_REG_IDX;
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DEPTH-1:0]        valid_q, valid_d;
  logic [DEPTH-1:0]        dep_q [DEPTH];
  logic [DEPTH-1:0]        dep_d [DEPTH];
  logic [PHYS_REG_SZ-1:0]  fl_snap_q [DEPTH];
  logic [PHYS_REG_SZ-1:0]  fl_snap_d [DEPTH];
  logic [MT_W-1:0]         mt_snap_q [DEPTH];
  logic [MT_W-1:0]         mt_snap_d [DEPTH];
  logic [ROB_IDX_BITS-1:0] rob_snap_q [DEPTH];
  logic [ROB_IDX_BITS-1:0] rob_snap_d [DEPTH];

  logic             hit;
  logic             mispredict;
  logic [IDX_W-1:0] hit_idx;
  logic             alloc_free;
  logic             alloc_en;
  logic [IDX_W-1:0] alloc_idx;

  assign branch_stack_full   = &valid_q;
  assign current_branch_mask = valid_q;

  // A resolve only counts when its one-hot mask names a currently valid entry.
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int k = 0; k < DEPTH; k++) begin
      if (resolve_valid && valid_q[k] && (resolve_mask == (DEPTH'(1) << k))) begin
        hit     = 1'b1;
        hit_idx = IDX_W'(k);
      end
    end
    mispredict    = hit && resolve_mispredict;
    resolved_mask = (hit && !resolve_mispredict) ? resolve_mask : '0;
    squash_mask   = '0;
    if (mispredict) begin
      for (int j = 0; j < DEPTH; j++) begin
        squash_mask[j] = (j == int'(hit_idx)) || (valid_q[j] && dep_q[j][hit_idx]);
      end
    end
    restore_flag      = mispredict;
    free_list_restore = mispredict ? fl_snap_q[hit_idx]  : '0;
    map_table_restore = mispredict ? mt_snap_q[hit_idx]  : '0;
    rob_tail_restore  = mispredict ? rob_snap_q[hit_idx] : '0;
  end

  // Allocation looks only at registered valid bits, so a slot freed this cycle waits a cycle.
  always_comb begin
    alloc_free = 1'b0;
    alloc_idx  = '0;
    for (int j = DEPTH - 1; j >= 0; j--) begin
      if (!valid_q[j]) begin
        alloc_free = 1'b1;
        alloc_idx  = IDX_W'(j);
      end
    end
    alloc_en             = branch_dispatch_valid && alloc_free && !mispredict;
    assigned_branch_mask = alloc_en ? (DEPTH'(1) << alloc_idx) : '0;
  end

  always_comb begin
    valid_d = (valid_q & ~resolved_mask & ~squash_mask) | assigned_branch_mask;
    for (int j = 0; j < DEPTH; j++) begin
      dep_d[j]      = dep_q[j] & ~resolved_mask;
      fl_snap_d[j]  = fl_snap_q[j];
      mt_snap_d[j]  = mt_snap_q[j];
      rob_snap_d[j] = rob_snap_q[j];
      if (assigned_branch_mask[j]) begin
        dep_d[j]      = valid_q & ~resolved_mask;
        fl_snap_d[j]  = free_list_snapshot;
        mt_snap_d[j]  = map_table_snapshot;
        rob_snap_d[j] = rob_tail_snapshot;
      end
      if (!valid_d[j]) begin
        dep_d[j] = '0;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      valid_q <= '0;
      for (int j = 0; j < DEPTH; j++) begin
        dep_q[j] <= '0;
      end
    end else begin
      valid_q <= valid_d;
      for (int j = 0; j < DEPTH; j++) begin
        dep_q[j] <= dep_d[j];
      end
    end
  end

  // Snapshot payload needs no reset; it is only read behind a valid bit.
  always_ff @(posedge clock) begin
    for (int j = 0; j < DEPTH; j++) begin
      fl_snap_q[j]  <= fl_snap_d[j];
      mt_snap_q[j]  <= mt_snap_d[j];
      rob_snap_q[j] <= rob_snap_d[j];
    end
  end

endmodule

// File: tb/tb_branch_stack.sv
// Self-checking bench for branch_stack: directed scenarios then random traffic,
// checked against an age-ordered list model of the in-flight branches.
module tb_branch_stack;

  localparam int DEPTH  = 4;
  localparam int ROB_W  = 5;
  localparam int PHYS   = 64;
  localparam int ARCH   = 32;
  localparam int PIDX   = 6;
  localparam int MT_W   = ARCH * PIDX;

  logic              clock = 1'b0;
  logic              reset = 1'b0;
  logic              branch_dispatch_valid = 1'b0;
  logic [PHYS-1:0]   free_list_snapshot = '0;
  logic [MT_W-1:0]   map_table_snapshot = '0;
  logic [ROB_W-1:0]  rob_tail_snapshot = '0;
  logic              resolve_valid = 1'b0;
  logic [DEPTH-1:0]  resolve_mask = '0;
  logic              resolve_mispredict = 1'b0;
  logic              branch_stack_full;
  logic [DEPTH-1:0]  assigned_branch_mask;
  logic [DEPTH-1:0]  current_branch_mask;
  logic [DEPTH-1:0]  resolved_mask;
  logic [DEPTH-1:0]  squash_mask;
  logic              restore_flag;
  logic [PHYS-1:0]   free_list_restore;
  logic [MT_W-1:0]   map_table_restore;
  logic [ROB_W-1:0]  rob_tail_restore;

  branch_stack #(
    .DEPTH(DEPTH), .ROB_IDX_BITS(ROB_W), .PHYS_REG_SZ(PHYS),
    .ARCH_REG_SZ(ARCH), .PHYS_REG_IDX(PIDX)
  ) dut (
    .clock(clock), .reset(reset),
    .branch_dispatch_valid(branch_dispatch_valid),
    .free_list_snapshot(free_list_snapshot),
    .map_table_snapshot(map_table_snapshot),
    .rob_tail_snapshot(rob_tail_snapshot),
    .resolve_valid(resolve_valid), .resolve_mask(resolve_mask),
    .resolve_mispredict(resolve_mispredict),
    .branch_stack_full(branch_stack_full),
    .assigned_branch_mask(assigned_branch_mask),
    .current_branch_mask(current_branch_mask),
    .resolved_mask(resolved_mask), .squash_mask(squash_mask),
    .restore_flag(restore_flag),
    .free_list_restore(free_list_restore),
    .map_table_restore(map_table_restore),
    .rob_tail_restore(rob_tail_restore)
  );

  always #5 clock = ~clock;

  int errors = 0;
  int checks = 0;

  // Model: entry indices of in-flight branches, oldest first, plus their snapshots.
  int               order[$];
  logic [PHYS-1:0]  fl_m  [DEPTH];
  logic [MT_W-1:0]  mt_m  [DEPTH];
  logic [ROB_W-1:0] rob_m [DEPTH];

  task automatic checkOutput(input string tag, input logic [255:0] actual, input logic [255:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
    end
  endtask

  function automatic bit inUse(int idx);
    foreach (order[p]) if (order[p] == idx) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [MT_W-1:0] randMap();
    logic [MT_W-1:0] m;
    for (int w = 0; w < MT_W / 32; w++) m[w*32 +: 32] = $urandom;
    return m;
  endfunction

  task automatic applyStimulus(input logic rst, input logic disp, input logic [PHYS-1:0] fl,
                               input logic [MT_W-1:0] mt, input logic [ROB_W-1:0] rob,
                               input logic rv, input logic [DEPTH-1:0] rmask, input logic misp);
    int k, pos, a;
    logic [DEPTH-1:0] e_sq, e_res, e_asg, e_cur;
    logic [PHYS-1:0]  e_fl;
    logic [MT_W-1:0]  e_mt;
    logic [ROB_W-1:0] e_rob;
    logic             e_rf, e_full;
    reset = rst; branch_dispatch_valid = disp;
    free_list_snapshot = fl; map_table_snapshot = mt; rob_tail_snapshot = rob;
    resolve_valid = rv; resolve_mask = rmask; resolve_mispredict = misp;
    #2;
    k = -1; pos = -1; a = -1;
    if (rv) for (int i = 0; i < DEPTH; i++) if (int'(rmask) == (1 << i)) k = i;
    if (k >= 0) foreach (order[p]) if (order[p] == k) pos = p;
    e_sq = '0; e_res = '0; e_asg = '0; e_cur = '0;
    e_fl = '0; e_mt = '0; e_rob = '0; e_rf = 1'b0;
    if (pos >= 0 && misp) begin
      e_rf = 1'b1; e_fl = fl_m[k]; e_mt = mt_m[k]; e_rob = rob_m[k];
      for (int p = pos; p < order.size(); p++) e_sq[order[p]] = 1'b1;
    end
    if (pos >= 0 && !misp) e_res = rmask;
    if (disp && order.size() < DEPTH && !(pos >= 0 && misp)) begin
      for (int i = DEPTH - 1; i >= 0; i--) if (!inUse(i)) a = i;
      e_asg[a] = 1'b1;
    end
    foreach (order[p]) e_cur[order[p]] = 1'b1;
    e_full = (order.size() == DEPTH);
    checkOutput("full", branch_stack_full, e_full);
    checkOutput("current", current_branch_mask, e_cur);
    checkOutput("assigned", assigned_branch_mask, e_asg);
    checkOutput("resolved", resolved_mask, e_res);
    checkOutput("squash", squash_mask, e_sq);
    checkOutput("restore_flag", restore_flag, e_rf);
    checkOutput("fl_restore", free_list_restore, e_fl);
    checkOutput("mt_restore", map_table_restore, e_mt);
    checkOutput("rob_restore", rob_tail_restore, e_rob);
    @(posedge clock);
    #1;
    if (rst) begin
      order.delete();
    end else begin
      if (pos >= 0 && misp) while (order.size() > pos) void'(order.pop_back());
      else if (pos >= 0) order.delete(pos);
      if (a >= 0) begin
        order.push_back(a);
        fl_m[a] = fl; mt_m[a] = mt; rob_m[a] = rob;
      end
    end
  endtask

  task automatic idle();
    applyStimulus(1'b0, 1'b0, '0, '0, '0, 1'b0, '0, 1'b0);
  endtask

  task automatic dispatch(input logic [PHYS-1:0] fl, input logic [ROB_W-1:0] rob);
    applyStimulus(1'b0, 1'b1, fl, randMap(), rob, 1'b0, '0, 1'b0);
  endtask

  task automatic resolve(input logic [DEPTH-1:0] m, input logic misp, input logic disp);
    applyStimulus(1'b0, disp, PHYS'(64'hDEAD_BEEF_0BAD_F00D), randMap(), 5'd9, 1'b1, m, misp);
  endtask

  task automatic fillFour();
    dispatch(PHYS'(64'h0000_0000_0000_0F0F), 5'd3);
    dispatch(PHYS'(64'hFFFF_0000_0000_F0F0), 5'd7);
    dispatch(PHYS'(64'h1234_5678_9ABC_DEF0), 5'd12);
    dispatch(PHYS'(64'h0F0F_0F0F_0F0F_0F0F), 5'd30);
  endtask

  initial begin
    applyStimulus(1'b1, 1'b0, '0, '0, '0, 1'b0, '0, 1'b0);
    idle();
    fillFour();
    checkOutput("plan_full_mask", current_branch_mask, 4'b1111);
    dispatch('1, 5'd1);
    // Mispredict the second branch: restores its snapshot and squashes everything younger.
    resolve(4'b0010, 1'b1, 1'b0);
    checkOutput("plan_after_squash", current_branch_mask, 4'b0001);
    dispatch(PHYS'(64'hAAAA), 5'd4);
    resolve(4'b0001, 1'b0, 1'b0);
    resolve(4'b0010, 1'b1, 1'b0);
    idle();
    fillFour();
    resolve(4'b0100, 1'b0, 1'b1);
    dispatch(PHYS'(64'h5555), 5'd5);
    idle();
    resolve(4'b0001, 1'b1, 1'b1);
    checkOutput("plan_empty", current_branch_mask, 4'b0000);
    dispatch(PHYS'(64'h77), 5'd6);
    resolve(4'b0100, 1'b0, 1'b0);
    resolve(4'b0100, 1'b1, 1'b0);
    dispatch(PHYS'(64'h99), 5'd8);
    applyStimulus(1'b1, 1'b0, '0, '0, '0, 1'b1, 4'b0001, 1'b1);
    idle();

    for (int c = 0; c < 600; c++) begin
      logic [DEPTH-1:0] m;
      logic rst;
      m = '0;
      if (order.size() > 0 && $urandom_range(0, 99) < 80)
        m[order[$urandom_range(0, order.size() - 1)]] = 1'b1;
      else
        m[$urandom_range(0, DEPTH - 1)] = 1'b1;
      rst = ($urandom_range(0, 99) < 2);
      applyStimulus(rst, ($urandom_range(0, 99) < 60), {$urandom, $urandom}, randMap(),
                    ROB_W'($urandom), ($urandom_range(0, 99) < 40), m,
                    ($urandom_range(0, 99) < 35));
    end
    idle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/branch_stack.md
# branch_stack

Checkpoint store between dispatch and the free-list/map-table rename state. It allocates one checkpoint per dispatched branch, capturing the free list, the map table and the ROB tail. It hands each branch a one-hot tag, then frees the tag on a correct resolve or restores the snapshot and squashes younger tags on a mispredict. Its restore outputs drive the free list's `free_list_restore`/`restore_flag` inputs directly.

## Interface
- DEPTH, 4, number of checkpoints (max in-flight unresolved branches)
- ROB_IDX_BITS, 5, width of ROB tail pointer
- clock  in  1  system clock
- reset  in  1  synchronous, active-high
- branch_dispatch_valid  in  1  allocate a checkpoint this cycle
- free_list_snapshot  in  `PHYS_REG_SZ_R10K  free list as seen by the dispatching branch
- map_table_snapshot  in  `ARCH_REG_SZ_R10K x PHYS_REG_IDX  map table at the branch
- rob_tail_snapshot  in  ROB_IDX_BITS  ROB tail after the branch
- resolve_valid  in  1  a branch resolves this cycle
- resolve_mask  in  DEPTH  one-hot tag of the resolving branch
- resolve_mispredict  in  1  1 = mispredict, 0 = correct
- branch_stack_full  out  DEPTH-bit-reduced 1  no free entry (registered state only)
- assigned_branch_mask  out  DEPTH  one-hot tag granted this cycle (0 if none)
- current_branch_mask  out  DEPTH  valid tags; dispatch tags instructions with it
- resolved_mask  out  DEPTH  tag cleared by a correct resolve this cycle
- squash_mask  out  DEPTH  mispredicted tag plus all younger tags
- restore_flag  out  1  mispredict restore active this cycle
- free_list_restore  out  `PHYS_REG_SZ_R10K  snapshot of the mispredicted entry
- map_table_restore  out  `ARCH_REG_SZ_R10K x PHYS_REG_IDX  same entry's map table
- rob_tail_restore  out  ROB_IDX_BITS  same entry's ROB tail

## Operation
- State per entry:
  - valid bit
  - dep mask (DEPTH bits, the older entries this entry depends on)
  - the three snapshots
- Allocation: when `branch_dispatch_valid` is high and the stack is not full, take the lowest-index invalid entry.
  - Set `assigned_branch_mask` to that one-hot.
  - Write the snapshots.
  - Set dep = `current_branch_mask` & ~`resolved_mask`.
- A hit is a resolve whose `resolve_mask` matches a valid entry k. A resolve with no valid match is ignored: all resolve outputs are 0.
- Correct resolve of k:
  - Clear valid[k] and clear bit k in every dep mask.
  - `resolved_mask` = `resolve_mask`.
- Mispredict of k:
  - `restore_flag` = 1, and the restore outputs carry entry k's snapshots.
  - `squash_mask` = bit k | {j : valid[j] && dep[j][k]}.
  - Every entry in `squash_mask` is invalidated.
- Mispredict in the same cycle as a dispatch: the allocation is dropped. The new branch is younger, so nothing is written and `assigned_branch_mask` = 0.
- Correct resolve in the same cycle as a dispatch: the allocation proceeds. The freed entry cannot be reused until the next cycle.
- Full: `branch_stack_full` = &valid. A dispatch while full is ignored, and dispatch must stall.
- `branch_dispatch_valid` while full is a protocol error; the block ignores it silently.

## Timing
- `branch_stack_full` and `current_branch_mask` derive from registered state.
- `assigned_branch_mask`, `resolved_mask`, `squash_mask`, `restore_flag` and the restore buses are combinational from the same-cycle inputs. This gives zero-latency restore into the free list's next-state logic.
- Entry valid/dep/snapshot updates take effect at the next rising edge.
- Reset (any cycle, including mid-restore) clears all valid and dep bits at the next edge.
  - After reset: `branch_stack_full`=0, `current_branch_mask`=0.
  - All combinational outputs are 0 while inputs are idle.
  - Snapshot contents are don't-care.
- Back-to-back dispatch is allowed every cycle until full.
- The cycle after a mispredict, `current_branch_mask` excludes every squashed tag.

## Test plan
- Reset, then 4 back-to-back dispatches (DEPTH=4) -> `assigned_branch_mask` 0001, 0010, 0100, 1000; `current_branch_mask` then 1111 and `branch_stack_full`=1; a 5th dispatch -> `assigned_branch_mask`=0 and state unchanged.
- With tags 0001..1000 allocated in order, mispredict on 0010 -> `restore_flag`=1, `squash_mask`=1110, restore buses equal the second snapshot (e.g. free list 0x..F0F0, ROB tail 7); next cycle `current_branch_mask`=0001.
- Correct resolve of 0001 while 0010 is valid -> `resolved_mask`=0001; then mispredict 0010 -> `squash_mask`=0010 only (bit 0 cleared from dep).
- Full stack, correct resolve of 0100 plus dispatch in the same cycle -> dispatch ignored; next cycle `branch_stack_full`=0, and a dispatch gets 0100.
- Mispredict of 0001 plus dispatch in the same cycle -> no allocation; next cycle `current_branch_mask`=0000.
- Resolve with mask 0100 when entry 2 is invalid -> all resolve outputs 0, state unchanged; assert reset during a mispredict cycle -> next cycle all outputs 0.
